frame_pixel_writer: RTL
=======================

FRAME_PIXEL_WRITER -- requirements
Module: frame_pixel_writer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, meaning screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 480, meaning screen height in pixels.
REQ-003 SHALL have parameter COLOR_W, default 8, meaning bits per colour channel.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning input pixel buffer entries (power of two, >=2).
REQ-005 SHALL derive X_W=clog2(SCREEN_W), Y_W=clog2(SCREEN_H), PIX_W=3*COLOR_W.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  pixel offered.
REQ-009 in_ready  out  1  pixel accepted when in_valid && in_ready.
REQ-010 in_x  in  X_W; in_y  in  Y_W  pixel coordinates.
REQ-011 in_red, in_green, in_blue  in  COLOR_W each  pixel colour.
REQ-012 clear_req  in  1  single-cycle request to fill the whole frame with clear_color.
REQ-013 clear_color  in  PIX_W  {r,g,b} fill value, sampled with clear_req.
REQ-014 rd_en  in  1; rd_x  in  X_W; rd_y  in  Y_W  frame read request.
REQ-015 rd_data  out  PIX_W  {r,g,b} read result.
REQ-016 busy  out  1  FIFO non-empty or clear in progress.
REQ-017 clear_done  out  1  one-cycle pulse at end of clear sweep.
REQ-018 oob_count  out  16  saturating count of dropped out-of-bounds pixels.

Function
REQ-019 Frame SHALL be SCREEN_W*SCREEN_H words of PIX_W, address = y*SCREEN_W + x.
REQ-020 in_ready SHALL equal "FIFO not full"; accepted pixels enter the FIFO in order.
REQ-021 FSM states SHALL be IDLE and CLEAR.
REQ-022 IDLE: if FIFO non-empty, pop one entry per cycle; in-bounds (x<SCREEN_W, y<SCREEN_H) -> frame write same cycle; otherwise drop and increment oob_count (saturate at 16'hFFFF).
REQ-023 Write latency SHALL be: pixel accepted in cycle N is visible to a read issued in cycle N+2 or later (empty FIFO).
REQ-024 clear_req in IDLE SHALL latch clear_color, enter CLEAR next cycle, address counter = 0; pop in that cycle is suppressed.
REQ-025 CLEAR: one word written per cycle, address incrementing; after writing last address (SCREEN_W*SCREEN_H-1) pulse clear_done and return to IDLE.
REQ-026 During CLEAR the FIFO SHALL keep accepting until full but SHALL NOT pop; queued pixels are written after the clear.
REQ-027 clear_req during CLEAR SHALL be ignored.
REQ-028 Simultaneous accept and pop on a full FIFO SHALL not occur (in_ready low when full); accept and pop on non-full SHALL keep count unchanged.
REQ-029 Read: rd_en in cycle N -> rd_data valid cycle N+1; out-of-bounds read returns 0; rd_data holds when rd_en low.
REQ-030 Read and write to same address same cycle SHALL return old data.
REQ-031 busy SHALL be high whenever state=CLEAR or FIFO count>0.

Reset
REQ-032 reset_n low SHALL immediately force: state IDLE, FIFO empty, in_ready=1, busy=0, clear_done=0, oob_count=0, rd_data=0.
REQ-033 Frame memory contents SHALL be undefined after reset; reset mid-CLEAR aborts the sweep without clear_done.

Structure
REQ-034 Shared package SHALL hold default SCREEN_W/SCREEN_H/COLOR_W constants and the state encoding.
REQ-035 Input buffer SHALL be a separate sub-module pixel_fifo (parametrised width, depth).

Verification
REQ-036 Write (3,2) rgb 55/F0/0F, wait 2 cycles, read (3,2) -> rd_data=24'h55F00F next cycle.
REQ-037 Push x=640,y=0 then x=0,y=480 -> no frame change, oob_count=2; 65537 OOB pixels -> oob_count=16'hFFFF.
REQ-038 Hold in_valid, never pop (clear active) -> in_ready falls after exactly FIFO_DEPTH accepts.
REQ-039 clear_req with 24'h123456 (SCREEN_W=8,SCREEN_H=4) -> clear_done exactly 32 cycles after CLEAR entry; every read returns 24'h123456; pixel pushed during clear then lands at its address.
REQ-040 Assert reset_n low mid-CLEAR -> busy=0, in_ready=1, oob_count=0 asynchronously; no clear_done pulse.
REQ-041 Diagonal stimulus: 100 pixels (i,i) for SCREEN_W=SCREEN_H=128 -> all 100 readback match, all others hold clear value.

Source files
------------

// File: rtl/frame_pixel_writer_pkg.sv
// Shared defaults and FSM encoding for the frame pixel writer.
package frame_pixel_writer_pkg;
  localparam int SCREEN_W_DEF   = 640;
  localparam int SCREEN_H_DEF   = 480;
  localparam int COLOR_W_DEF    = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam logic [15:0] OOB_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/frame_pixel_writer_if.sv
// Pixel input, clear control, frame read port and status of the frame pixel writer.
interface frame_pixel_writer_if
  import frame_pixel_writer_pkg::*;
#(
  parameter int X_W     = $clog2(SCREEN_W_DEF),
  parameter int Y_W     = $clog2(SCREEN_H_DEF),
  parameter int COLOR_W = COLOR_W_DEF
);
  localparam int PIX_W = 3*COLOR_W;

  logic               in_valid;
  logic               in_ready;
  logic [X_W-1:0]     in_x;
  logic [Y_W-1:0]     in_y;
  logic [COLOR_W-1:0] in_red;
  logic [COLOR_W-1:0] in_green;
  logic [COLOR_W-1:0] in_blue;
  logic               clear_req;
  logic [PIX_W-1:0]   clear_color;
  logic               rd_en;
  logic [X_W-1:0]     rd_x;
  logic [Y_W-1:0]     rd_y;
  logic [PIX_W-1:0]   rd_data;
  logic               busy;
  logic               clear_done;
  logic [15:0]        oob_count;

  modport master (
    output in_valid, in_x, in_y, in_red, in_green, in_blue,
           clear_req, clear_color, rd_en, rd_x, rd_y,
    input  in_ready, rd_data, busy, clear_done, oob_count
  );

  modport slave (
    input  in_valid, in_x, in_y, in_red, in_green, in_blue,
           clear_req, clear_color, rd_en, rd_x, rd_y,
    output in_ready, rd_data, busy, clear_done, oob_count
  );
endinterface

// File: rtl/frame_pixel_writer_pixel_fifo.sv
// Small synchronous FIFO buffering incoming pixels; head entry is visible combinationally.
module pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end
endmodule

// File: rtl/frame_pixel_writer.sv
// Frame buffer writer: queued pixel writes, full-frame clear sweep, registered read port.
module frame_pixel_writer
  import frame_pixel_writer_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int COLOR_W    = COLOR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  frame_pixel_writer_if.slave bus
);
  localparam int X_W    = $clog2(SCREEN_W);
  localparam int Y_W    = $clog2(SCREEN_H);
  localparam int PIX_W  = 3*COLOR_W;
  localparam int DEPTH  = SCREEN_W*SCREEN_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ENT_W  = X_W + Y_W + PIX_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

  function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
  endfunction

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
  endfunction

  state_t             r_state, w_next;
  logic [PIX_W-1:0]   r_frame [DEPTH];
  logic [ADDR_W-1:0]  r_clr_addr;
  logic [PIX_W-1:0]   r_clr_color;
  logic               r_clear_done;
  logic [15:0]        r_oob;
  logic [PIX_W-1:0]   r_rd_data;

  logic               w_full, w_empty, w_pop;
  logic [ENT_W-1:0]   w_head;
  logic [X_W-1:0]     w_hx;
  logic [Y_W-1:0]     w_hy;
  logic [PIX_W-1:0]   w_hpix;
  logic               w_clr_start, w_clr_we, w_clr_last;
  logic               w_pix_we, w_oob_hit, w_rd_inb;
  logic [ADDR_W-1:0]  w_pix_addr, w_rd_addr;

  pixel_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (bus.in_valid),
    .i_din   ({bus.in_x, bus.in_y, bus.in_red, bus.in_green, bus.in_blue}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_hx, w_hy, w_hpix} = w_head;
  assign w_pix_addr = fb_addr(w_hx, w_hy);
  assign w_pix_we   = w_pop && in_bounds(w_hx, w_hy);
  assign w_oob_hit  = w_pop && !in_bounds(w_hx, w_hy);
  assign w_rd_addr  = fb_addr(bus.rd_x, bus.rd_y);
  assign w_rd_inb   = in_bounds(bus.rd_x, bus.rd_y);

  assign bus.in_ready   = !w_full;
  assign bus.busy       = (r_state == ST_CLEAR) || !w_empty;
  assign bus.clear_done = r_clear_done;
  assign bus.oob_count  = r_oob;
  assign bus.rd_data    = r_rd_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // A clear request wins over a pending pop; the FIFO keeps filling while the sweep runs.
  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_clr_start = 1'b0;
    w_clr_we    = 1'b0;
    w_clr_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.clear_req) begin
          w_clr_start = 1'b1;
          w_next      = ST_CLEAR;
        end else if (!w_empty) begin
          w_pop = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_addr == LAST_ADDR) begin
          w_clr_last = 1'b1;
          w_next     = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_addr   <= '0;
      r_clr_color  <= '0;
      r_clear_done <= 1'b0;
      r_oob        <= '0;
    end else begin
      if (w_clr_start) begin
        r_clr_addr  <= '0;
        r_clr_color <= bus.clear_color;
      end else if (w_clr_we) begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
      r_clear_done <= w_clr_last;
      if (w_oob_hit && r_oob != OOB_MAX) r_oob <= r_oob + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we)      r_frame[r_clr_addr] <= r_clr_color;
    else if (w_pix_we) r_frame[w_pix_addr] <= w_hpix;
  end

  // Same-edge read of an address being written returns the previous contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_rd_data <= '0;
    else if (bus.rd_en) r_rd_data <= w_rd_inb ? r_frame[w_rd_addr] : '0;
  end
endmodule
